sccb_tick_gen: RTL and testbench



---
 rtl/sccb_clk_pkg.sv | 30 +++
 rtl/sccb_tick_gen_if.sv | 33 +++
 rtl/sccb_lock_debounce.sv | 43 ++++
 rtl/sccb_tick_gen.sv | 130 +++++++++++++
 tb/tb_sccb_tick_gen.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sccb_clk_pkg.sv
// Shared definitions for the SCCB bit timebase.
//   state_t       : timebase FSM states (IDLE, RUN, DRAIN)
//   PH_*          : the four quarter phases of one SCCB bit
//   MIN_QDIV      : smallest quarter-period the divider accepts
//   default_qdiv  : quarter-period in fabric cycles for a given clock / bit rate
//   scl_level     : ideal SIO_C level during a given phase
package sccb_clk_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [1:0] PH_SETUP  = 2'd0;  // SIO_C low, shifter launches SIO_D
    localparam logic [1:0] PH_RISE   = 2'd1;  // SIO_C high
    localparam logic [1:0] PH_SAMPLE = 2'd2;  // SIO_C high, shifter samples SIO_D
    localparam logic [1:0] PH_FALL   = 2'd3;  // SIO_C low

    localparam int MIN_QDIV = 2;

    function automatic int default_qdiv(input int clk_hz, input int sccb_hz);
        return clk_hz / (4 * sccb_hz);
    endfunction

    function automatic logic scl_level(input logic [1:0] ph);
        return (ph == PH_RISE) || (ph == PH_SAMPLE);
    endfunction

endpackage

// File: rtl/sccb_tick_gen_if.sv
// Control/status bundle between the SCCB master and its bit timebase.
//   EN        : level request to run the timebase
//   DIV_LOAD  : one-cycle strobe loading DIV_VALUE (quarter-period, CLK cycles)
//   CLK_READY : debounced CCC lock
//   BUSY      : timebase not idle
//   PHASE     : current quarter within the bit
//   TICK      : one-cycle pulse at the end of each phase
//   BIT_DONE  : one-cycle pulse at the end of phase 3
//   SCL_OUT   : ideal SIO_C level
// master drives the requests, slave is the timebase.
interface sccb_tick_gen_if #(
    parameter int DIV_W = 16
);
    logic             EN;
    logic             DIV_LOAD;
    logic [DIV_W-1:0] DIV_VALUE;
    logic             CLK_READY;
    logic             BUSY;
    logic [1:0]       PHASE;
    logic             TICK;
    logic             BIT_DONE;
    logic             SCL_OUT;

    modport master (
        output EN, DIV_LOAD, DIV_VALUE,
        input  CLK_READY, BUSY, PHASE, TICK, BIT_DONE, SCL_OUT
    );

    modport slave (
        input  EN, DIV_LOAD, DIV_VALUE,
        output CLK_READY, BUSY, PHASE, TICK, BIT_DONE, SCL_OUT
    );
endinterface

// File: rtl/sccb_lock_debounce.sv
// Debounces the CCC lock into CLK_READY.
//   CLK       : fabric clock
//   RESET     : synchronous, active-high reset
//   PLL_LOCK  : CCC lock, asynchronous to CLK
//   CLK_READY : high after LOCK_DEBOUNCE consecutive synchronised-high cycles,
//               low one cycle after the synchronised lock drops
module sccb_lock_debounce #(
    parameter int LOCK_DEBOUNCE = 256
) (
    input  logic CLK,
    input  logic RESET,
    input  logic PLL_LOCK,
    output logic CLK_READY
);
    localparam int CNT_W = (LOCK_DEBOUNCE > 1) ? $clog2(LOCK_DEBOUNCE) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOCK_DEBOUNCE - 1);

    logic             lock_meta;
    logic             lock_sync;
    logic [CNT_W-1:0] cnt;

    // NOTE: sequential state uses non-blocking assignments so the two
    // synchroniser flops shift rather than collapse into one.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            lock_meta <= 1'b0;
            lock_sync <= 1'b0;
            cnt       <= '0;
            CLK_READY <= 1'b0;
        end else begin
            lock_meta <= PLL_LOCK;
            lock_sync <= lock_meta;
            if (!lock_sync) begin
                cnt <= '0;
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + 1'b1;
            end
            // Registered so a dropped lock clears READY on the very next edge,
            // while the rise lands LOCK_DEBOUNCE cycles after sync goes high.
            CLK_READY <= lock_sync && (cnt == CNT_MAX);
        end
    end
endmodule

// File: rtl/sccb_tick_gen.sv
// SCCB bit timebase: divides CLK into four equal phases per SCCB bit and
// drives the ideal SIO_C level plus phase/bit strobes.
//   CLK      : fabric clock after the CCC
//   RESET    : synchronous, active-high reset
//   PLL_LOCK : CCC lock, asynchronous to CLK
//   bus      : control/status bundle (slave side), see sccb_tick_gen_if
module sccb_tick_gen
    import sccb_clk_pkg::*;
#(
    parameter int CLK_FREQ_HZ   = 50000000,
    parameter int SCCB_FREQ_HZ  = 100000,
    parameter int DIV_W         = 16,
    parameter int LOCK_DEBOUNCE = 256
) (
    input  logic           CLK,
    input  logic           RESET,
    input  logic           PLL_LOCK,
    sccb_tick_gen_if.slave bus
);
    localparam logic [DIV_W-1:0] DEFAULT_QDIV = DIV_W'(default_qdiv(CLK_FREQ_HZ, SCCB_FREQ_HZ));
    localparam logic [DIV_W-1:0] MIN_Q        = DIV_W'(MIN_QDIV);

    logic clk_ready;

    sccb_lock_debounce #(
        .LOCK_DEBOUNCE(LOCK_DEBOUNCE)
    ) u_lock (
        .CLK      (CLK),
        .RESET    (RESET),
        .PLL_LOCK (PLL_LOCK),
        .CLK_READY(clk_ready)
    );

    state_t           state, state_nxt;
    logic [DIV_W-1:0] qdiv, qdiv_nxt;
    logic [DIV_W-1:0] cnt, cnt_nxt;
    logic [DIV_W-1:0] div_clamped;
    logic [DIV_W-1:0] start_qdiv;
    logic [1:0]       phase, phase_nxt;
    logic             tick, tick_nxt;
    logic             bit_done, bit_done_nxt;
    logic             scl, scl_nxt;
    logic             busy;

    // NOTE: every variable written here gets a default first; a missed
    // branch would otherwise infer a latch.
    always_comb begin
        div_clamped  = (bus.DIV_VALUE < MIN_Q) ? MIN_Q : bus.DIV_VALUE;
        start_qdiv   = qdiv;
        state_nxt    = state;
        qdiv_nxt     = qdiv;
        cnt_nxt      = cnt;
        phase_nxt    = phase;
        tick_nxt     = 1'b0;
        bit_done_nxt = 1'b0;
        scl_nxt      = scl;

        case (state)
            IDLE: begin
                if (bus.DIV_LOAD) begin
                    qdiv_nxt   = div_clamped;
                    // A load coinciding with the start governs the first phase.
                    start_qdiv = div_clamped;
                end
                if (bus.EN && clk_ready) begin
                    state_nxt = RUN;
                    cnt_nxt   = start_qdiv - 1'b1;
                    phase_nxt = PH_SETUP;
                    scl_nxt   = scl_level(PH_SETUP);
                end
            end
            default: begin  // RUN and DRAIN count identically; EN only picks the label
                if (!clk_ready) begin
                    // Lock lost: abandon the bit with no strobes.
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                    phase_nxt = PH_SETUP;
                    scl_nxt   = 1'b1;
                end else if (cnt != '0) begin
                    cnt_nxt   = cnt - 1'b1;
                    state_nxt = bus.EN ? RUN : DRAIN;
                end else begin
                    tick_nxt     = 1'b1;
                    bit_done_nxt = (phase == PH_FALL);
                    phase_nxt    = phase + 2'd1;
                    if (phase == PH_FALL && !bus.EN) begin
                        // Bit boundary with no request pending: park high.
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                        phase_nxt = PH_SETUP;
                        scl_nxt   = 1'b1;
                    end else begin
                        state_nxt = bus.EN ? RUN : DRAIN;
                        cnt_nxt   = qdiv - 1'b1;
                        scl_nxt   = scl_level(phase_nxt);
                    end
                end
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state    <= IDLE;
            qdiv     <= DEFAULT_QDIV;
            cnt      <= '0;
            phase    <= PH_SETUP;
            tick     <= 1'b0;
            bit_done <= 1'b0;
            scl      <= 1'b1;
            busy     <= 1'b0;
        end else begin
            state    <= state_nxt;
            qdiv     <= qdiv_nxt;
            cnt      <= cnt_nxt;
            phase    <= phase_nxt;
            tick     <= tick_nxt;
            bit_done <= bit_done_nxt;
            scl      <= scl_nxt;
            busy     <= (state_nxt != IDLE);
        end
    end

    assign bus.CLK_READY = clk_ready;
    assign bus.BUSY      = busy;
    assign bus.PHASE     = phase;
    assign bus.TICK      = tick;
    assign bus.BIT_DONE  = bit_done;
    assign bus.SCL_OUT   = scl;
endmodule

// File: tb/tb_sccb_tick_gen.sv
// Self-checking bench for sccb_tick_gen: lock debounce, default-divisor
// waveform, per-cycle vector table at qdiv=2, lock loss and relock.
module tb_sccb_tick_gen;

    logic clk;
    logic rst;
    logic pll_lock;

    sccb_tick_gen_if #(.DIV_W(16)) bus ();

    sccb_tick_gen #(
        .CLK_FREQ_HZ  (50000000),
        .SCCB_FREQ_HZ (100000),
        .DIV_W        (16),
        .LOCK_DEBOUNCE(256)
    ) dut (
        .CLK     (clk),
        .RESET   (rst),
        .PLL_LOCK(pll_lock),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        en;
        logic        ld;
        logic [15:0] val;
        logic        busy;
        logic [1:0]  ph;
        logic        tick;
        logic        done;
        logic        scl;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input int en, input int ld, input int val, input int busy,
                                input int ph, input int tick, input int done, input int scl);
        vec_t r;
        r.en   = (en != 0);
        r.ld   = (ld != 0);
        r.val  = 16'(val);
        r.busy = (busy != 0);
        r.ph   = 2'(ph);
        r.tick = (tick != 0);
        r.done = (done != 0);
        r.scl  = (scl != 0);
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Advance one clock; sample 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (!bus.CLK_READY && n < 1000) begin
            step();
            n++;
        end
    endtask

    task automatic wait_tick(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!bus.TICK && n < 1000);
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (bus.BUSY && n < 1000) begin
            step();
            n++;
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int n;
    int ph_m;
    logic exp_scl, exp_tick, exp_done, prev_scl;
    int bad_scl, bad_tick, bad_done, bad_phase;
    int rise_t[$];
    int fall_t[$];
    int done_t[$];
    int tick_t[$];
    int done_cnt;

    initial begin
        rst           = 1'b1;
        pll_lock      = 1'b0;
        bus.EN        = 1'b0;
        bus.DIV_LOAD  = 1'b0;
        bus.DIV_VALUE = '0;
        repeat (3) step();

        // ---- reset state
        check("rst_clk_ready", 32'(bus.CLK_READY), 32'd0);
        check("rst_busy",      32'(bus.BUSY),      32'd0);
        check("rst_phase",     32'(bus.PHASE),     32'd0);
        check("rst_tick",      32'(bus.TICK),      32'd0);
        check("rst_bit_done",  32'(bus.BIT_DONE),  32'd0);
        check("rst_scl",       32'(bus.SCL_OUT),   32'd1);
        rst = 1'b0;
        step();

        // ---- lock glitch restarts the debounce, then 2+256 cycles to READY
        pll_lock = 1'b1;
        repeat (100) step();
        check("glitch_ready_low", 32'(bus.CLK_READY), 32'd0);
        pll_lock = 1'b0;
        repeat (4) step();
        pll_lock = 1'b1;
        wait_ready(n);
        check("lock_to_ready_cycles", 32'(n), 32'd258);

        // ---- default divisor: qdiv=125, 500-cycle bit
        bus.EN = 1'b1;
        step();
        check("start_latency_scl", 32'(bus.SCL_OUT), 32'd0);
        check("start_busy",        32'(bus.BUSY),    32'd1);
        check("start_phase",       32'(bus.PHASE),   32'd0);
        bad_scl = 0; bad_tick = 0; bad_done = 0; bad_phase = 0;
        prev_scl = 1'b0;
        for (int c = 1; c <= 1100; c++) begin
            step();
            ph_m     = (c / 125) % 4;
            exp_scl  = (ph_m == 1) || (ph_m == 2);
            exp_tick = (c % 125) == 0;
            exp_done = (c % 500) == 0;
            if (bus.SCL_OUT !== exp_scl)    bad_scl++;
            if (bus.TICK !== exp_tick)      bad_tick++;
            if (bus.BIT_DONE !== exp_done)  bad_done++;
            if (32'(bus.PHASE) !== 32'(ph_m)) bad_phase++;
            if (bus.SCL_OUT && !prev_scl) rise_t.push_back(c);
            if (!bus.SCL_OUT && prev_scl) fall_t.push_back(c);
            if (bus.BIT_DONE) done_t.push_back(c);
            if (bus.TICK) tick_t.push_back(c);
            prev_scl = bus.SCL_OUT;
        end
        check("dflt_scl_bad_cycles",   32'(bad_scl),   32'd0);
        check("dflt_tick_bad_cycles",  32'(bad_tick),  32'd0);
        check("dflt_done_bad_cycles",  32'(bad_done),  32'd0);
        check("dflt_phase_bad_cycles", 32'(bad_phase), 32'd0);
        if (rise_t.size() >= 2 && fall_t.size() >= 1 && done_t.size() >= 2 && tick_t.size() >= 2) begin
            check("dflt_first_low",  32'(rise_t[0]),             32'd125);
            check("dflt_high_time",  32'(fall_t[0] - rise_t[0]), 32'd250);
            check("dflt_low_time",   32'(rise_t[1] - fall_t[0]), 32'd250);
            check("dflt_bit_period", 32'(done_t[1] - done_t[0]), 32'd500);
            check("dflt_tick_space", 32'(tick_t[1] - tick_t[0]), 32'd125);
        end else begin
            check("dflt_edge_count", 32'(rise_t.size() + fall_t.size()), 32'd4);
        end
        // EN dropped at c=1100 (phase 0 of third bit): bit ends at c=1500.
        bus.EN = 1'b0;
        wait_idle(n);
        check("dflt_drain_cycles", 32'(n),             32'd400);
        check("dflt_drain_done",   32'(bus.BIT_DONE),  32'd1);
        check("dflt_drain_scl",    32'(bus.SCL_OUT),   32'd1);

        // ---- per-cycle table at qdiv=2 (DIV_VALUE=1 clamped), loads in RUN ignored
        //              en ld val  busy ph tick done scl
        vecs.push_back(mk(0, 1, 1,   0, 0, 0, 0, 1));
        vecs.push_back(mk(1, 0, 0,   1, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0,   1, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 10,  1, 1, 1, 0, 1));
        vecs.push_back(mk(1, 0, 0,   1, 1, 0, 0, 1));
        vecs.push_back(mk(1, 0, 0,   1, 2, 1, 0, 1));
        vecs.push_back(mk(1, 0, 0,   1, 2, 0, 0, 1));
        vecs.push_back(mk(1, 0, 0,   1, 3, 1, 0, 0));
        vecs.push_back(mk(1, 0, 0,   1, 3, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0,   1, 0, 1, 1, 0));
        vecs.push_back(mk(1, 1, 10,  1, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0,   1, 1, 1, 0, 1));
        // EN dropped in phase 1: bit completes, then IDLE
        vecs.push_back(mk(0, 0, 0,   1, 1, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0,   1, 2, 1, 0, 1));
        vecs.push_back(mk(0, 0, 0,   1, 2, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0,   1, 3, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0,   1, 3, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0,   0, 0, 1, 1, 1));
        vecs.push_back(mk(0, 0, 0,   0, 0, 0, 0, 1));
        // restart, drop EN in phase 1, reassert in phase 2 of DRAIN
        vecs.push_back(mk(1, 0, 0,   1, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0,   1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0,   1, 1, 1, 0, 1));
        vecs.push_back(mk(0, 0, 0,   1, 1, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0,   1, 2, 1, 0, 1));
        vecs.push_back(mk(1, 0, 0,   1, 2, 0, 0, 1));
        vecs.push_back(mk(1, 0, 0,   1, 3, 1, 0, 0));
        vecs.push_back(mk(1, 0, 0,   1, 3, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0,   1, 0, 1, 1, 0));
        vecs.push_back(mk(1, 0, 0,   1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0,   1, 1, 1, 0, 1));
        vecs.push_back(mk(0, 0, 0,   1, 1, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0,   1, 2, 1, 0, 1));
        vecs.push_back(mk(0, 0, 0,   1, 2, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0,   1, 3, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0,   1, 3, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0,   0, 0, 1, 1, 1));
        vecs.push_back(mk(0, 0, 0,   0, 0, 0, 0, 1));

        foreach (vecs[i]) begin
            bus.EN        = vecs[i].en;
            bus.DIV_LOAD  = vecs[i].ld;
            bus.DIV_VALUE = vecs[i].val;
            step();
            check($sformatf("vec%0d_busy", i),  32'(bus.BUSY),     32'(vecs[i].busy));
            check($sformatf("vec%0d_phase", i), 32'(bus.PHASE),    32'(vecs[i].ph));
            check($sformatf("vec%0d_tick", i),  32'(bus.TICK),     32'(vecs[i].tick));
            check($sformatf("vec%0d_done", i),  32'(bus.BIT_DONE), 32'(vecs[i].done));
            check($sformatf("vec%0d_scl", i),   32'(bus.SCL_OUT),  32'(vecs[i].scl));
        end

        // ---- DIV_LOAD=20 with EN in the same IDLE cycle: first phase is 20 long
        bus.DIV_LOAD  = 1'b1;
        bus.DIV_VALUE = 16'd20;
        bus.EN        = 1'b1;
        step();
        bus.DIV_LOAD  = 1'b0;
        check("load_start_busy", 32'(bus.BUSY), 32'd1);
        wait_tick(n);
        check("load_first_phase_len", 32'(n),         32'd20);
        check("load_phase_after",     32'(bus.PHASE), 32'd1);

        // ---- lock loss 5 cycles into phase 2
        repeat (25) step();
        check("pre_loss_phase", 32'(bus.PHASE), 32'd2);
        pll_lock = 1'b0;
        done_cnt = 0;
        step(); if (bus.BIT_DONE) done_cnt++;
        step(); if (bus.BIT_DONE) done_cnt++;
        check("loss_ready_still_high", 32'(bus.CLK_READY), 32'd1);
        step(); if (bus.BIT_DONE) done_cnt++;
        check("loss_ready_low_3cyc",   32'(bus.CLK_READY), 32'd0);
        check("loss_busy_until_next",  32'(bus.BUSY),      32'd1);
        step(); if (bus.BIT_DONE) done_cnt++;
        check("loss_idle_busy",  32'(bus.BUSY),    32'd0);
        check("loss_idle_scl",   32'(bus.SCL_OUT), 32'd1);
        check("loss_idle_phase", 32'(bus.PHASE),   32'd0);
        check("loss_idle_tick",  32'(bus.TICK),    32'd0);
        for (int k = 0; k < 30; k++) begin
            step();
            if (bus.BIT_DONE) done_cnt++;
        end
        check("loss_no_bit_done", 32'(done_cnt), 32'd0);
        check("loss_stays_idle",  32'(bus.BUSY), 32'd0);

        // ---- relock with EN held: restart only after the full debounce
        pll_lock = 1'b1;
        n = 0;
        while (!bus.BUSY && n < 1000) begin
            step();
            n++;
        end
        check("relock_restart_cycles", 32'(n),           32'd259);
        check("relock_scl_low",        32'(bus.SCL_OUT), 32'd0);
        wait_tick(n);
        check("relock_first_phase", 32'(n), 32'd20);
        bus.EN = 1'b0;
        wait_idle(n);
        check("relock_drain_cycles", 32'(n),            32'd60);
        check("relock_drain_done",   32'(bus.BIT_DONE), 32'd1);
        check("relock_drain_scl",    32'(bus.SCL_OUT),  32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
